mem_wb: RTL
===========

MEM_WB -- requirements
Module: mem_wb

Interface
REQ-001 clk  in  1  rising-edge clock for all state.
REQ-002 rst  in  1  reset; asynchronous, active-high.
REQ-003 stall  in  6  pipeline stall vector; bit 4 = MEM stage stalled, bit 5 = WB stage stalled.
REQ-004 flush  in  1  exception/pipeline flush request.
REQ-005 mem_wd  in  5  destination register address from MEM.
REQ-006 mem_wreg  in  1  register-write enable from MEM.
REQ-007 mem_wdata  in  32  ALU result, or old rt value for LWL/LWR merge.
REQ-008 mem_ld_en  in  1  MEM-stage instruction is a load.
REQ-009 mem_ld_type  in  3  load kind: 0 LB, 1 LBU, 2 LH, 3 LHU, 4 LW, 5 LWL, 6 LWR, 7 reserved.
REQ-010 mem_addr_lo  in  2  byte offset (address bits 1:0) of the load.
REQ-011 ram_rdata  in  32  synchronous data-RAM read word, valid in the cycle after the address is presented (WB cycle).
REQ-012 wb_wd  out  5  regfile write address.
REQ-013 wb_wreg  out  1  regfile write enable.
REQ-014 wb_wdata  out  32  regfile write data.
REQ-015 wb_is_load  out  1  WB holds a load; consumed by the hazard unit.

Function
REQ-016 The block SHALL hold one registered entry: wd, wreg, wdata, ld_en, ld_type, addr_lo.
REQ-017 Update priority at each rising clk edge (rst low) SHALL be: flush -> bubble; else stall[4]=1 and stall[5]=0 -> bubble; else stall[4]=1 and stall[5]=1 -> hold; else capture MEM inputs.
REQ-018 A bubble SHALL set all registered fields to zero.
REQ-019 Capture with mem_wd = 0 SHALL register wreg = 0; $0 is never written.
REQ-020 wb_wd, wb_wreg, wb_is_load SHALL be direct outputs of the registered wd, wreg, ld_en.
REQ-021 When registered ld_en = 0, wb_wdata SHALL equal registered wdata; when ld_en = 1 it SHALL be formed combinationally from ram_rdata in the same cycle (zero added latency).
REQ-022 Byte lanes are big-endian: offset 0 = ram_rdata[31:24], offset 3 = ram_rdata[7:0].
REQ-023 LB/LBU SHALL select the byte at addr_lo; LB sign-extends, LBU zero-extends to 32 bits.
REQ-024 LH/LHU SHALL select the halfword by addr_lo[1] (0 -> [31:16], 1 -> [15:0]), ignoring addr_lo[0]; LH sign-extends, LHU zero-extends.
REQ-025 LW and reserved type 7 SHALL return ram_rdata unmodified regardless of addr_lo.
REQ-026 LWL by offset SHALL produce (old = registered wdata, d = ram_rdata): 0 -> d; 1 -> {d[23:0], old[7:0]}; 2 -> {d[15:0], old[15:0]}; 3 -> {d[7:0], old[23:0]}.
REQ-027 LWR by offset SHALL produce: 0 -> {old[31:8], d[31:24]}; 1 -> {old[31:16], d[31:16]}; 2 -> {old[31:24], d[31:8]}; 3 -> d.
REQ-028 During hold, wb_wdata for a load SHALL track the current ram_rdata; the RAM controller holds ram_rdata stable while stall[5] = 1.
REQ-029 flush asserted coincident with any stall combination SHALL produce a bubble.

Reset
REQ-030 Asserting rst SHALL immediately, without waiting for clk, clear all registered fields to zero: wb_wd = 0, wb_wreg = 0, wb_wdata = 0, wb_is_load = 0.
REQ-031 While rst is high, clk edges SHALL NOT change state; the first capture occurs on the first rising clk edge after rst falls.
REQ-032 Reset asserted mid-stall or mid-load SHALL discard the entry; no regfile write follows.

Verification
REQ-033 ALU pass: mem_wd = 3, mem_wreg = 1, mem_wdata = 0x12345678, stall = 0 -> next cycle wb_wd = 3, wb_wreg = 1, wb_wdata = 0x12345678, wb_is_load = 0.
REQ-034 Loads with ram_rdata = 0x80FF7F01: LB off 0 -> 0xFFFFFF80; LBU off 1 -> 0x000000FF; LH off 2 -> 0x00007F01; LH off 0 -> 0xFFFF80FF; LW off 3 -> 0x80FF7F01.
REQ-035 Unaligned merge, old = 0xAABBCCDD, ram_rdata = 0x11223344: LWL off 1 -> 0x223344DD; LWR off 1 -> 0xAABB1122; LWL off 3 -> 0x44BBCCDD; LWR off 3 -> 0x11223344.
REQ-036 Stall/flush sequence, valid entry in WB: stall = 6'b110000 for 2 cycles -> outputs held; stall = 6'b010000 -> next cycle wb_wreg = 0, wb_wdata = 0; flush = 1 with stall = 6'b110000 -> bubble.
REQ-037 Capture with mem_wd = 0, mem_wreg = 1 -> wb_wreg = 0.
REQ-038 Async reset: with wb_wreg = 1, assert rst between clock edges -> wb_wreg = 0 and wb_wd = 0 before the next clk edge.

Source files
------------

// File: rtl/mem_wb.sv
// ---------------------------------------------------------------------------
// mem_wb -- MEM/WB pipeline register with load-data formatting.
//
// Holds one pipeline entry (destination, write enable, data, load info)
// between the memory and write-back stages. Loads are finished here: the
// synchronous data RAM returns its word in the WB cycle, so the byte/half
// selection, extension and LWL/LWR merge are done combinationally on
// ram_rdata with no added latency.
//
// Ports
//   clk          in   1  rising-edge clock
//   rst          in   1  asynchronous active-high reset
//   stall        in   6  stall vector (bit 4 = MEM stalled, bit 5 = WB stalled)
//   flush        in   1  exception/pipeline flush, forces a bubble
//   mem_wd       in   5  destination register from MEM
//   mem_wreg     in   1  register-write enable from MEM
//   mem_wdata    in  32  ALU result, or old rt value for LWL/LWR
//   mem_ld_en    in   1  MEM instruction is a load
//   mem_ld_type  in   3  0 LB, 1 LBU, 2 LH, 3 LHU, 4 LW, 5 LWL, 6 LWR, 7 rsvd
//   mem_addr_lo  in   2  byte offset of the load address
//   ram_rdata    in  32  data-RAM read word, valid in the WB cycle
//   wb_wd        out  5  regfile write address
//   wb_wreg      out  1  regfile write enable
//   wb_wdata     out 32  regfile write data
//   wb_is_load   out  1  WB holds a load (hazard unit)
// ---------------------------------------------------------------------------
module mem_wb (
   input  logic        clk,
   input  logic        rst,
   input  logic [5:0]  stall,
   input  logic        flush,
   input  logic [4:0]  mem_wd,
   input  logic        mem_wreg,
   input  logic [31:0] mem_wdata,
   input  logic        mem_ld_en,
   input  logic [2:0]  mem_ld_type,
   input  logic [1:0]  mem_addr_lo,
   input  logic [31:0] ram_rdata,
   output logic [4:0]  wb_wd,
   output logic        wb_wreg,
   output logic [31:0] wb_wdata,
   output logic        wb_is_load
);

   logic [4:0]  wd_r;
   logic        wreg_r;
   logic [31:0] wdata_r;
   logic        ld_en_r;
   logic [2:0]  ld_type_r;
   logic [1:0]  addr_lo_r;
   logic [31:0] load_data_s;

   // Byte offsets are big-endian: offset 0 is the most significant byte.
   function automatic logic [31:0] format_load(
      input logic [2:0]  ld_type,
      input logic [1:0]  off,
      input logic [31:0] old,
      input logic [31:0] d
   );
      logic [7:0]  byte_v;
      logic [15:0] half_v;
      logic [31:0] res_v;
      case (off)
         2'd0:    byte_v = d[31:24];
         2'd1:    byte_v = d[23:16];
         2'd2:    byte_v = d[15:8];
         2'd3:    byte_v = d[7:0];
         default: byte_v = 8'h00;
      endcase
      // Halfword alignment ignores offset bit 0.
      half_v = off[1] ? d[15:0] : d[31:16];
      case (ld_type)
         3'd0:    res_v = {{24{byte_v[7]}}, byte_v};
         3'd1:    res_v = {24'h000000, byte_v};
         3'd2:    res_v = {{16{half_v[15]}}, half_v};
         3'd3:    res_v = {16'h0000, half_v};
         3'd5: begin
            case (off)
               2'd0:    res_v = d;
               2'd1:    res_v = {d[23:0], old[7:0]};
               2'd2:    res_v = {d[15:0], old[15:0]};
               2'd3:    res_v = {d[7:0],  old[23:0]};
               default: res_v = d;
            endcase
         end
         3'd6: begin
            case (off)
               2'd0:    res_v = {old[31:8],  d[31:24]};
               2'd1:    res_v = {old[31:16], d[31:16]};
               2'd2:    res_v = {old[31:24], d[31:8]};
               2'd3:    res_v = d;
               default: res_v = d;
            endcase
         end
         default: res_v = d;   // LW and reserved type 7 pass the word through
      endcase
      return res_v;
   endfunction

   // Pipeline entry: flush beats everything, a MEM-only stall inserts a
   // bubble, a MEM+WB stall holds, otherwise the MEM inputs are captured.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wd_r      <= 5'd0;
         wreg_r    <= 1'b0;
         wdata_r   <= 32'h0000_0000;
         ld_en_r   <= 1'b0;
         ld_type_r <= 3'd0;
         addr_lo_r <= 2'd0;
      end else if (flush || (stall[4] && !stall[5])) begin
         wd_r      <= 5'd0;
         wreg_r    <= 1'b0;
         wdata_r   <= 32'h0000_0000;
         ld_en_r   <= 1'b0;
         ld_type_r <= 3'd0;
         addr_lo_r <= 2'd0;
      end else if (stall[4] && stall[5]) begin
         wd_r      <= wd_r;
         wreg_r    <= wreg_r;
         wdata_r   <= wdata_r;
         ld_en_r   <= ld_en_r;
         ld_type_r <= ld_type_r;
         addr_lo_r <= addr_lo_r;
      end else begin
         wd_r      <= mem_wd;
         // $0 is hard-wired zero, so never request a write to it.
         wreg_r    <= mem_wreg && (mem_wd != 5'd0);
         wdata_r   <= mem_wdata;
         ld_en_r   <= mem_ld_en;
         ld_type_r <= mem_ld_type;
         addr_lo_r <= mem_addr_lo;
      end
   end

   // Load result is built from the RAM word arriving this cycle.
   always_comb begin
      load_data_s = format_load(ld_type_r, addr_lo_r, wdata_r, ram_rdata);
   end

   // Write-back data mux: formatted load word or the registered result.
   always_comb begin
      if (ld_en_r) begin
         wb_wdata = load_data_s;
      end else begin
         wb_wdata = wdata_r;
      end
   end

   assign wb_wd      = wd_r;
   assign wb_wreg    = wreg_r;
   assign wb_is_load = ld_en_r;

endmodule
